apb_master_ctrl: RTL

APB master controller sitting between the AXI4-lite front end and the APB slave fabric. It accepts one request per `transfer` pulse, decodes the target slave from the address, and sequences the APB SETUP and ACCESS phases. It enforces a bounded wait on `PREADY` and returns one completion pulse with an AXI-encoded response, which feeds RRESP/BRESP directly.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_addr_decoder.sv | 26 ++
 rtl/apb_master_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master controller.
package apb_pkg;

  // One-hot FSM encoding; any other value is treated as illegal and recovers to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SETUP  = 3'b010,
    ST_ACCESS = 3'b100
  } state_e;

  // AXI-encoded completion responses, fed straight into RRESP/BRESP.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/apb_addr_decoder.sv
// Address-to-slave decoder: slave index, one-hot select and out-of-range flag.
module apb_addr_decoder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_SEL_LSB = 12,
  localparam int IDX_W      = $clog2(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel_onehot,
  output logic                  dec_err
);

  // Every address bit above the slave-index field must be zero to hit a slave.
  localparam logic [ADDR_WIDTH-1:0] HI_MASK =
    ~((ADDR_WIDTH'(1) << (SLV_SEL_LSB + IDX_W)) - ADDR_WIDTH'(1));

  // Pure combinational decode of the index field and the upper address bits.
  always_comb begin
    idx             = addr[SLV_SEL_LSB +: IDX_W];
    sel_onehot      = '0;
    sel_onehot[idx] = 1'b1;
    dec_err         = (addr & HI_MASK) != '0;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: one request per transfer strobe, SETUP/ACCESS sequencing,
// bounded PREADY wait and a single-cycle AXI-encoded completion.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for transfer; decode errors complete from here
//   ST_SETUP  | PSEL asserted, PENABLE low, one cycle
//   ST_ACCESS | PENABLE high, waiting on PREADY or the timeout
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_SEL_LSB    = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             transfer,
  input  logic                             read,
  input  logic                             write,
  input  logic [ADDR_WIDTH-1:0]            apb_waddr,
  input  logic [ADDR_WIDTH-1:0]            apb_raddr,
  input  logic [DATA_WIDTH-1:0]            apb_wdata,
  input  logic [3:0]                       apb_strb,
  output logic                             apb_done,
  output logic [1:0]                       apb_resp,
  output logic [DATA_WIDTH-1:0]            apb_rdata,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [3:0]                       PSTRB,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int IDX_W = $clog2(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [3:0]              pstrb_q, pstrb_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    done_q, done_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;

  // A strobe with neither direction set carries no request and is ignored.
  logic                    req_valid;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_err;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  assign req_valid = transfer && (read || write);
  assign req_addr  = write ? apb_waddr : apb_raddr;

  apb_addr_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_SLAVES  (NUM_SLAVES),
    .SLV_SEL_LSB (SLV_SEL_LSB)
  ) u_dec (
    .addr       (req_addr),
    .idx        (dec_idx),
    .sel_onehot (dec_sel),
    .dec_err    (dec_err)
  );

  // Per-slave response muxes, steered by the latched slave index.
  always_comb begin
    sel_ready = PREADY[idx_q];
    sel_err   = PSLVERR[idx_q];
    sel_rdata = PRDATA[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  // State and output registers; reset drops any in-flight request silently.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      done_q     <= done_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; decode errors never leave IDLE, PREADY beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid && !dec_err) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (sel_ready || (wait_cnt_q == CNT_LAST)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; PADDR and PWDATA hold after the transfer ends.
  always_comb begin
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    done_d     = 1'b0;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    busy_d     = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_err) begin
            done_d  = 1'b1;
            resp_d  = RESP_DECERR;
            rdata_d = '0;
          end else begin
            idx_d     = dec_idx;
            paddr_d   = req_addr;
            pwrite_d  = write;
            pwdata_d  = write ? apb_wdata : '0;
            pstrb_d   = write ? apb_strb : '0;
            psel_d    = dec_sel;
            penable_d = 1'b0;
          end
        end
      end
      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          done_d    = 1'b1;
          resp_d    = sel_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d   = pwrite_q ? '0 : sel_rdata;
          psel_d    = '0;
          penable_d = 1'b0;
        end else if (wait_cnt_q == CNT_LAST) begin
          done_d    = 1'b1;
          resp_d    = RESP_SLVERR;
          rdata_d   = '0;
          psel_d    = '0;
          penable_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign apb_done  = done_q;
  assign apb_resp  = resp_q;
  assign apb_rdata = rdata_q;
  assign busy      = busy_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;

endmodule
